// File: rtl/lisnoc16_usb_to_noc.sv
`default_nettype none
// ============================================================================
// Module      : lisnoc16_usb_to_noc
// Description : Receive side of the USB <-> debug-NoC bridge. Removes the
//               zero-word bulk padding from the usb-module word stream,
//               parses length-prefixed frames and emits typed 18-bit
//               lisnoc16 flits. Frames longer than MAX_LEN are consumed
//               and discarded, and err_oversize pulses once for each.
// Revision    : 1.0 - initial release
// ============================================================================
module lisnoc16_usb_to_noc #(
    parameter int MAX_LEN   = 32,   // matches MAX_NOC16_PACKET_LENGTH
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,            // synchronous, active-low
    input  logic [15:0] in_usb_data,
    input  logic        in_usb_valid,
    output logic        in_usb_ready,
    output logic [17:0] out_noc_data,
    output logic        out_noc_valid,
    input  logic        out_noc_ready,
    output logic        err_oversize
);

    // Parser states
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_push = 2'd1;
    localparam logic [1:0] c_st_drop = 2'd2;

    // lisnoc16 flit types
    localparam logic [1:0] c_type_payload = 2'b00;
    localparam logic [1:0] c_type_header  = 2'b01;
    localparam logic [1:0] c_type_last    = 2'b10;
    localparam logic [1:0] c_type_single  = 2'b11;

    localparam logic [31:0]          c_max_len = 32'(MAX_LEN);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [CNT_WIDTH-1:0] r_remaining;
    logic                 r_first;
    logic [17:0]          r_out_data;
    logic                 r_out_valid;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_load_flit;
    logic [1:0]           w_flit_type;
    logic                 w_is_last_word;
    logic                 w_len_zero;
    logic                 w_len_oversize;

    // The whole 16-bit length word is compared; nothing is truncated.
    assign w_len_zero     = (in_usb_data == 16'd0);
    assign w_len_oversize = ({16'd0, in_usb_data} > c_max_len);
    assign w_is_last_word = (r_remaining == c_cnt_one);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: frame parsing driven by accepted words only
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept && !w_len_zero) begin
                    w_next_state = w_len_oversize ? c_st_drop : c_st_push;
                end
            end
            c_st_push, c_st_drop: begin
                if (w_accept && w_is_last_word) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Output logic: back-pressure only matters when a word turns into a flit
    always_comb begin
        in_usb_ready = 1'b1;
        w_load_flit  = 1'b0;
        w_flit_type  = c_type_payload;
        if (r_state == c_st_push) begin
            in_usb_ready = !r_out_valid || out_noc_ready;
        end
        w_accept = in_usb_valid && in_usb_ready;
        if (r_state == c_st_push) begin
            w_load_flit = w_accept;
            if (r_first && w_is_last_word) begin
                w_flit_type = c_type_single;
            end else if (r_first) begin
                w_flit_type = c_type_header;
            end else if (w_is_last_word) begin
                w_flit_type = c_type_last;
            end else begin
                w_flit_type = c_type_payload;
            end
        end
    end

    // Word counter and first-word flag; the counter never wraps below zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_remaining <= c_cnt_zero;
            r_first     <= 1'b0;
        end else if (w_accept) begin
            if (r_state == c_st_idle) begin
                if (!w_len_zero) begin
                    r_remaining <= CNT_WIDTH'(in_usb_data);
                    r_first     <= 1'b1;
                end
            end else begin
                if (r_remaining != c_cnt_zero) begin
                    r_remaining <= r_remaining - c_cnt_one;
                end
                r_first <= 1'b0;
            end
        end
    end

    // Single output register stage; contents hold while the NoC stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 18'd0;
        end else if (w_load_flit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {w_flit_type, in_usb_data};
        end else if (out_noc_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // One-cycle error pulse for an oversize length word
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && (r_state == c_st_idle) && w_len_oversize;
        end
    end

    assign out_noc_data  = r_out_data;
    assign out_noc_valid = r_out_valid;
    assign err_oversize  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lisnoc16_usb_to_noc.sv
`default_nettype none
// ============================================================================
// Module      : tb_lisnoc16_usb_to_noc
// Description : Self-checking bench for lisnoc16_usb_to_noc. Cycle-exact
//               vector table for the directed frames, a hand-written reset
//               sequence, and a randomized frame stream checked against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lisnoc16_usb_to_noc;

    localparam int MAX_LEN = 32;

    logic        clk;
    logic        rst;
    logic [15:0] in_usb_data;
    logic        in_usb_valid;
    logic        in_usb_ready;
    logic [17:0] out_noc_data;
    logic        out_noc_valid;
    logic        out_noc_ready;
    logic        err_oversize;

    int checks;
    int errors;

    lisnoc16_usb_to_noc #(
        .MAX_LEN   (MAX_LEN),
        .CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_usb_data   (in_usb_data),
        .in_usb_valid  (in_usb_valid),
        .in_usb_ready  (in_usb_ready),
        .out_noc_data  (out_noc_data),
        .out_noc_valid (out_noc_valid),
        .out_noc_ready (out_noc_ready),
        .err_oversize  (err_oversize)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus and the outputs expected while it is applied
    typedef struct {
        logic        rst;
        logic        v;
        logic [15:0] d;
        logic        r;
        logic        exp_ov;
        logic [17:0] exp_od;
        logic        chk_od;
        logic        exp_irdy;
        logic        exp_err;
    } vec_t;

    vec_t rows[$];

    task automatic add(input logic v, input logic [15:0] d, input logic r,
                       input logic ov, input logic [17:0] od,
                       input logic irdy, input logic err);
        vec_t x;
        x.rst = 1'b1; x.v = v; x.d = d; x.r = r;
        x.exp_ov = ov; x.exp_od = od; x.chk_od = ov;
        x.exp_irdy = irdy; x.exp_err = err;
        rows.push_back(x);
    endtask

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, n, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, then compare the outputs
    task automatic apply_row(input vec_t x, input int n);
        @(negedge clk);
        rst           = x.rst;
        in_usb_valid  = x.v;
        in_usb_data   = x.d;
        out_noc_ready = x.r;
        #1;
        chk("out_noc_valid", n, 32'(out_noc_valid), 32'(x.exp_ov));
        chk("in_usb_ready",  n, 32'(in_usb_ready),  32'(x.exp_irdy));
        chk("err_oversize",  n, 32'(err_oversize),  32'(x.exp_err));
        if (x.chk_od) chk("out_noc_data", n, 32'(out_noc_data), 32'(x.exp_od));
    endtask

    // Reference flit type from a word's position inside its frame
    function automatic logic [1:0] ref_type(input int i, input int len);
        if (len == 1)           return 2'b11;
        else if (i == 0)        return 2'b01;
        else if (i == len - 1)  return 2'b10;
        else                    return 2'b00;
    endfunction

    // Random-stream state
    logic [15:0] words[$];
    logic [17:0] exp_q[$];
    int          exp_err_cnt;
    int          err_seen;

    initial begin
        vec_t x;
        int   idx;
        int   cyc;
        logic hold;
        logic [17:0] hold_data;
        logic [17:0] e;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        in_usb_valid = 1'b0;
        in_usb_data = 16'd0;
        out_noc_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Reset state
        x = '{rst: 1'b1, v: 1'b0, d: 16'd0, r: 1'b1, exp_ov: 1'b0, exp_od: 18'd0,
              chk_od: 1'b1, exp_irdy: 1'b1, exp_err: 1'b0};
        apply_row(x, -1);

        // Three-word frame at full rate
        add(1, 16'h0003, 1, 0, 18'h0,     1, 0);
        add(1, 16'hA001, 1, 0, 18'h0,     1, 0);
        add(1, 16'hA002, 1, 1, 18'h1A001, 1, 0);
        add(1, 16'hA003, 1, 1, 18'h0A002, 1, 0);
        // Single-word frame followed by ten padding words
        add(1, 16'h0001, 1, 1, 18'h2A003, 1, 0);
        add(1, 16'h1234, 1, 0, 18'h0,     1, 0);
        add(1, 16'h0000, 1, 1, 18'h31234, 1, 0);
        for (int i = 0; i < 9; i++) add(1, 16'h0000, 1, 0, 18'h0, 1, 0);
        // Three-word frame with the NoC stalled for three cycles
        add(1, 16'h0003, 1, 0, 18'h0,     1, 0);
        add(1, 16'hA001, 1, 0, 18'h0,     1, 0);
        for (int i = 0; i < 3; i++) add(1, 16'hA002, 0, 1, 18'h1A001, 0, 0);
        add(1, 16'hA002, 1, 1, 18'h1A001, 1, 0);
        add(1, 16'hA003, 1, 1, 18'h0A002, 1, 0);
        add(0, 16'h0000, 1, 1, 18'h2A003, 1, 0);
        add(0, 16'h0000, 1, 0, 18'h0,     1, 0);
        // Oversize frame of 33 words (including 0 and 1 values) is dropped
        add(1, 16'h0021, 1, 0, 18'h0, 1, 0);
        for (int i = 0; i < 33; i++) add(1, 16'(i), 1, 0, 18'h0, 1, (i == 0));
        add(1, 16'h0001, 1, 0, 18'h0,     1, 0);
        add(1, 16'hBEEF, 1, 0, 18'h0,     1, 0);
        add(0, 16'h0000, 1, 1, 18'h3BEEF, 1, 0);
        add(0, 16'h0000, 1, 0, 18'h0,     1, 0);
        // Zero words inside a frame are content
        add(1, 16'h0004, 1, 0, 18'h0,     1, 0);
        add(1, 16'h0000, 1, 0, 18'h0,     1, 0);
        add(1, 16'h0000, 1, 1, 18'h10000, 1, 0);
        add(1, 16'h0000, 1, 1, 18'h00000, 1, 0);
        add(1, 16'h0005, 1, 1, 18'h00000, 1, 0);
        add(0, 16'h0000, 1, 1, 18'h20005, 1, 0);
        add(0, 16'h0000, 1, 0, 18'h0,     1, 0);

        for (int i = 0; i < rows.size(); i++) apply_row(rows[i], i);

        // Reset in the middle of a frame abandons it
        add(1, 16'h0004, 1, 0, 18'h0,     1, 0);
        add(1, 16'h0A01, 1, 0, 18'h0,     1, 0);
        add(1, 16'h0A02, 1, 1, 18'h10A01, 1, 0);
        for (int i = 0; i < 3; i++) apply_row(rows[rows.size() - 3 + i], 100 + i);
        x = '{rst: 1'b0, v: 1'b0, d: 16'd0, r: 1'b1, exp_ov: 1'b1, exp_od: 18'h00A02,
              chk_od: 1'b1, exp_irdy: 1'b1, exp_err: 1'b0};
        apply_row(x, 103);
        x = '{rst: 1'b0, v: 1'b0, d: 16'd0, r: 1'b1, exp_ov: 1'b0, exp_od: 18'h0,
              chk_od: 1'b1, exp_irdy: 1'b1, exp_err: 1'b0};
        apply_row(x, 104);
        rows.delete();
        add(1, 16'h0002, 1, 0, 18'h0,     1, 0);
        add(1, 16'h0C01, 1, 0, 18'h0,     1, 0);
        add(1, 16'h0C02, 1, 1, 18'h10C01, 1, 0);
        add(0, 16'h0000, 1, 1, 18'h20C02, 1, 0);
        add(0, 16'h0000, 1, 0, 18'h0,     1, 0);
        for (int i = 0; i < rows.size(); i++) apply_row(rows[i], 105 + i);

        // Randomized frame stream against a frame-level model
        exp_err_cnt = 0;
        err_seen = 0;
        for (int f = 0; f < 40; f++) begin
            int pad;
            int len;
            bit big;
            pad = $urandom_range(0, 2);
            for (int p = 0; p < pad; p++) words.push_back(16'h0000);
            big = ($urandom_range(0, 9) == 0);
            len = big ? $urandom_range(MAX_LEN + 1, MAX_LEN + 8) : $urandom_range(1, MAX_LEN);
            words.push_back(16'(len));
            if (big) exp_err_cnt++;
            for (int i = 0; i < len; i++) begin
                logic [15:0] w;
                w = 16'($urandom);
                words.push_back(w);
                if (!big) exp_q.push_back({ref_type(i, len), w});
            end
        end

        idx = 0;
        cyc = 0;
        hold = 1'b0;
        hold_data = 18'd0;
        while (!(idx == words.size() && exp_q.size() == 0 && !out_noc_valid) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                chk("held valid", cyc, 32'(out_noc_valid), 32'd1);
                chk("held data",  cyc, 32'(out_noc_data),  32'(hold_data));
            end
            in_usb_valid  = (idx < words.size()) && ($urandom_range(0, 3) != 0);
            in_usb_data   = in_usb_valid ? words[idx] : 16'($urandom);
            out_noc_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (err_oversize) err_seen++;
            if (in_usb_valid && in_usb_ready) idx++;
            if (out_noc_valid && out_noc_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected flit", cyc, 32'(out_noc_data), 32'h3FFFF + 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("random flit", cyc, 32'(out_noc_data), 32'(e));
                end
            end
            hold = out_noc_valid && !out_noc_ready;
            hold_data = out_noc_data;
        end
        in_usb_valid = 1'b0;
        chk("random stream finished in budget", cyc, 32'(cyc < 20000), 32'd1);
        chk("random flits outstanding", cyc, 32'(exp_q.size()), 32'd0);
        chk("random oversize pulses", cyc, 32'(err_seen), 32'(exp_err_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
